// File: rtl/minmax_track.sv
// Windowed running min/max tracker.
// Collects WIN samples per window, tracks the running extremes, and publishes
// the completed window's extremes one cycle after the last sample is accepted.
module minmax_track #(
    parameter int WIN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sign,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [15:0] din,
    output logic        in_ready,
    output logic [15:0] cur_min,
    output logic [15:0] cur_max,
    output logic [7:0]  count,
    output logic        new_min,
    output logic        new_max,
    output logic [15:0] win_min,
    output logic [15:0] win_max,
    output logic        win_sign,
    output logic        done
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Count value at which the next accepted sample closes the window.
    localparam logic [7:0] LAST_COUNT = 8'(WIN - 1);

    state_t state_reg;
    logic   mode_reg;     // compare mode latched at the first sample of a window
    logic   accept;
    logic   below_min;
    logic   above_max;

    // Ready whenever a window can take a sample; clear and reset both block intake.
    always_comb begin
        in_ready = (state_reg != DONE) && !clear && !rst;
        accept   = in_valid && in_ready;
    end

    // Strict comparisons against the running extremes, using only the latched mode.
    always_comb begin
        below_min = 1'b0;
        above_max = 1'b0;
        if (mode_reg) begin
            below_min = $signed(din) < $signed(cur_min);
            above_max = $signed(din) > $signed(cur_max);
        end else begin
            below_min = din < cur_min;
            above_max = din > cur_max;
        end
    end

    // Window FSM with registered extremes, pulses and published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            mode_reg  <= 1'b0;
            count     <= 8'd0;
            cur_min   <= 16'h0000;
            cur_max   <= 16'h0000;
            win_min   <= 16'h0000;
            win_max   <= 16'h0000;
            win_sign  <= 1'b0;
            new_min   <= 1'b0;
            new_max   <= 1'b0;
            done      <= 1'b0;
        end else begin
            new_min <= 1'b0;
            new_max <= 1'b0;
            done    <= 1'b0;
            if (clear) begin
                // Abort: partial window dropped, published results untouched.
                state_reg <= EMPTY;
                count     <= 8'd0;
            end else begin
                case (state_reg)
                    EMPTY: begin
                        if (accept) begin
                            cur_min   <= din;
                            cur_max   <= din;
                            mode_reg  <= sign;
                            count     <= 8'd1;
                            new_min   <= 1'b1;
                            new_max   <= 1'b1;
                            state_reg <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (accept) begin
                            if (below_min) begin
                                cur_min <= din;
                                new_min <= 1'b1;
                            end
                            if (above_max) begin
                                cur_max <= din;
                                new_max <= 1'b1;
                            end
                            count <= count + 8'd1;
                            if (count == LAST_COUNT) begin
                                state_reg <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        // Publish the closed window; running extremes are kept.
                        win_min   <= cur_min;
                        win_max   <= cur_max;
                        win_sign  <= mode_reg;
                        done      <= 1'b1;
                        count     <= 8'd0;
                        state_reg <= EMPTY;
                    end
                    default: begin
                        state_reg <= EMPTY;
                        count     <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_minmax_track.sv
// Directed-vector bench for minmax_track (WIN = 8).
module tb_minmax_track;

    logic        clk = 1'b0;
    logic        rst;
    logic        sign;
    logic        clear;
    logic        in_valid;
    logic [15:0] din;
    logic        in_ready;
    logic [15:0] cur_min;
    logic [15:0] cur_max;
    logic [7:0]  count;
    logic        new_min;
    logic        new_max;
    logic [15:0] win_min;
    logic [15:0] win_max;
    logic        win_sign;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    minmax_track #(.WIN(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .sign     (sign),
        .clear    (clear),
        .in_valid (in_valid),
        .din      (din),
        .in_ready (in_ready),
        .cur_min  (cur_min),
        .cur_max  (cur_max),
        .count    (count),
        .new_min  (new_min),
        .new_max  (new_max),
        .win_min  (win_min),
        .win_max  (win_max),
        .win_sign (win_sign),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Count a comparison and report a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one sample for one clock edge; outputs are sampled 1 time unit later.
    task automatic push(input logic [15:0] v);
        in_valid = 1'b1;
        din      = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("push din=%h count=%0d new_min=%0b new_max=%0b", v, count, new_min, new_max);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] sv_vals [8];
    logic [15:0] stream  [16];
    logic [15:0] got_min [2];
    logic [15:0] got_max [2];

    initial begin
        int idx;
        int lows;
        int dones;
        logic rdy;

        rst = 1'b1; sign = 1'b0; clear = 1'b0; in_valid = 1'b0; din = 16'h0;
        step();
        in_valid = 1'b1;
        #1;
        chk("ready_low_in_reset", in_ready, 1'b0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("reset_count", count, 8'd0);
        chk("reset_cur_min", cur_min, 16'h0000);
        chk("reset_win_max", win_max, 16'h0000);
        chk("reset_done", done, 1'b0);
        chk("ready_after_reset", in_ready, 1'b1);

        // Signed window: 1,2,1,256,257,256,2,-1 -> min -1, max 257.
        sv_vals = '{16'd1, 16'd2, 16'd1, 16'd256, 16'd257, 16'd256, 16'd2, 16'hFFFF};
        sign = 1'b1;
        push(sv_vals[0]);
        chk("s_first_pulses", {new_min, new_max}, 2'b11);
        chk("s_first_count", count, 8'd1);
        push(sv_vals[1]);
        chk("s_second_pulses", {new_min, new_max}, 2'b01);
        push(sv_vals[2]);
        chk("s_tie_no_pulse", {new_min, new_max}, 2'b00);
        for (int i = 3; i < 8; i++) push(sv_vals[i]);
        chk("s_last_pulses", {new_min, new_max}, 2'b10);
        chk("s_count_win", count, 8'd8);
        chk("s_ready_low_done", in_ready, 1'b0);
        chk("s_done_not_yet", done, 1'b0);
        step();
        chk("s_done", done, 1'b1);
        chk("s_win_min", win_min, 16'hFFFF);
        chk("s_win_max", win_max, 16'd257);
        chk("s_win_sign", win_sign, 1'b1);
        chk("s_count_zero", count, 8'd0);
        chk("s_cur_hold", cur_min, 16'hFFFF);
        step();
        chk("s_done_one_cycle", done, 1'b0);

        // Unsigned window, same samples -> min 1, max FFFF.
        sign = 1'b0;
        for (int i = 0; i < 8; i++) push(sv_vals[i]);
        chk("u_last_pulses", {new_min, new_max}, 2'b01);
        step();
        chk("u_done", done, 1'b1);
        chk("u_win_min", win_min, 16'd1);
        chk("u_win_max", win_max, 16'hFFFF);
        chk("u_win_sign", win_sign, 1'b0);

        // Signed window with a mid-window switch to unsigned that must be ignored.
        sign = 1'b1;
        push(16'hFF00);            // -256
        push(16'h0101);            // 257
        chk("t_max_257", {new_min, new_max}, 2'b01);
        push(16'hFEFF);            // -257
        chk("t_min_m257", {new_min, new_max}, 2'b10);
        push(16'hFF00);            // -256 again
        chk("t_tie_m256", {new_min, new_max}, 2'b00);
        sign = 1'b0;
        push(16'h8000);            // -32768 in the latched signed mode
        chk("t_min_8000", {new_min, new_max}, 2'b10);
        push(16'h7FFF);            // +32767
        chk("t_max_7fff", {new_min, new_max}, 2'b01);
        push(16'h0000);
        push(16'h0000);
        chk("t_zero_no_pulse", {new_min, new_max}, 2'b00);
        step();
        chk("t_done", done, 1'b1);
        chk("t_win_min", win_min, 16'h8000);
        chk("t_win_max", win_max, 16'h7FFF);
        chk("t_win_sign", win_sign, 1'b1);

        // Clear after 5 samples drops the window and the sample offered with it.
        for (int i = 0; i < 5; i++) push(16'(10 * (i + 1)));
        chk("c_count5", count, 8'd5);
        clear = 1'b1; in_valid = 1'b1; din = 16'h0001;
        #1;
        chk("c_ready_low", in_ready, 1'b0);
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("c_count0", count, 8'd0);
        chk("c_no_done", done, 1'b0);
        chk("c_win_held", win_min, 16'h8000);

        // Back-to-back stream of two windows with in_valid held high.
        for (int i = 0; i < 8; i++) begin
            stream[i]     = 16'(100 + i);
            stream[i + 8] = 16'(300 - i);
        end
        idx = 0; lows = 0; dones = 0;
        for (int c = 0; c < 40 && !(idx == 16 && dones == 2); c++) begin
            in_valid = (idx < 16);
            din      = (idx < 16) ? stream[idx] : 16'h0;
            #1;
            rdy = in_ready;
            if (!rdy) lows++;
            @(posedge clk);
            #1;
            if (rdy && in_valid) idx++;
            if (done) begin
                if (dones < 2) begin
                    got_min[dones] = win_min;
                    got_max[dones] = win_max;
                end
                dones++;
            end
            if (idx == 8 && dones == 0) chk("b_prior_win_held", win_min, 16'h8000);
        end
        in_valid = 1'b0;
        chk("b_accepted", idx, 16);
        chk("b_done_pulses", dones, 2);
        chk("b_ready_low_cycles", lows, 2);
        chk("b_w0_min", got_min[0], 16'd100);
        chk("b_w0_max", got_max[0], 16'd107);
        chk("b_w1_min", got_min[1], 16'd293);
        chk("b_w1_max", got_max[1], 16'd300);

        // Clear during DONE suppresses the publish.
        for (int i = 0; i < 8; i++) push(16'(i + 1));
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("d_no_done", done, 1'b0);
        chk("d_win_min_held", win_min, 16'd293);
        chk("d_win_max_held", win_max, 16'd300);
        chk("d_count0", count, 8'd0);

        // Reset mid-window discards everything.
        sign = 1'b1;
        push(16'h1234);
        push(16'h0042);
        sign = 1'b0;
        push(16'h9000);
        rst = 1'b1; in_valid = 1'b1; din = 16'h5555;
        step();
        chk("r_ready_low", in_ready, 1'b0);
        chk("r_count", count, 8'd0);
        chk("r_cur_min", cur_min, 16'h0000);
        chk("r_cur_max", cur_max, 16'h0000);
        chk("r_win_min", win_min, 16'h0000);
        chk("r_win_sign", win_sign, 1'b0);
        chk("r_pulses", {new_min, new_max, done}, 3'b000);
        rst = 1'b0; in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/minmax_track.md
MINMAX_TRACK -- requirements
Module: minmax_track

Interface
REQ-001 The block SHALL have parameter WIN, default 8, giving the samples per window (legal range 2..255).
REQ-002 Port clk SHALL be input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit, synchronous active-high reset.
REQ-004 Port sign SHALL be input, 1 bit, compare mode: 1 = two's-complement signed, 0 = unsigned.
REQ-005 Port clear SHALL be input, 1 bit, a synchronous abort of the current window.
REQ-006 Port in_valid SHALL be input, 1 bit, meaning din holds a sample.
REQ-007 Port din SHALL be input, 16 bits, the sample value.
REQ-008 Port in_ready SHALL be output, 1 bit, meaning the block accepts a sample this cycle.
REQ-009 Ports cur_min and cur_max SHALL be outputs, 16 bits each, holding the running extremes of the open window.
REQ-010 Port count SHALL be output, 8 bits, giving the number of samples accepted in the open window.
REQ-011 Ports new_min and new_max SHALL be outputs, 1 bit each, a one-cycle pulse when the accepted sample strictly replaced the extreme.
REQ-012 Ports win_min and win_max SHALL be outputs, 16 bits each, holding the extremes of the last completed window.
REQ-013 Port win_sign SHALL be output, 1 bit, giving the compare mode used for the last completed window.
REQ-014 Port done SHALL be output, 1 bit, a one-cycle pulse when win_min, win_max and win_sign update.

Function
REQ-015 A sample SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-016 in_ready SHALL be combinational: high in states EMPTY and ACTIVE, low in state DONE, and low whenever clear=1.
REQ-017 The FSM SHALL have three states: EMPTY (no samples), ACTIVE (1..WIN-1 samples), and DONE (one cycle, window closing).
REQ-018 EMPTY SHALL go to ACTIVE on acceptance, with cur_min=cur_max=din, count=1 and sign latched as the window mode; new_min and new_max SHALL both pulse.
REQ-019 In ACTIVE, an accepted sample SHALL be compared against cur_min and cur_max using the latched mode only; a change of sign mid-window SHALL have no effect until the next window.
REQ-020 cur_min SHALL be replaced only when din < cur_min, and cur_max only when din > cur_max; equal values SHALL NOT update either extreme or pulse.
REQ-021 count SHALL increment by 1 per accepted sample.
REQ-022 On acceptance when count==WIN-1, the extremes SHALL update per REQ-020, count SHALL become WIN, and the state SHALL go to DONE.
REQ-023 In DONE, win_min and win_max SHALL receive cur_min and cur_max, win_sign SHALL receive the latched mode, and done SHALL be 1.
REQ-024 DONE SHALL then go to EMPTY with count=0; cur_min and cur_max SHALL hold their values.
REQ-025 done SHALL therefore assert exactly 1 cycle after the WIN-th acceptance, and a new sample SHALL be acceptable 2 cycles after the WIN-th acceptance.
REQ-026 new_min and new_max SHALL be registered and assert in the cycle after acceptance.
REQ-027 clear=1 in any state SHALL force EMPTY and count=0; any in_valid sample in that cycle SHALL be dropped.
REQ-028 win_min, win_max and win_sign SHALL be unchanged by clear, and done SHALL NOT pulse.
REQ-029 clear asserted in DONE SHALL take priority: no done pulse and no update of the win_* outputs.
REQ-030 Signed compares SHALL treat 16'h8000 as -32768 and 16'h7FFF as +32767; unsigned compares SHALL treat 16'hFFFF as the maximum value.

Reset
REQ-031 rst=1 SHALL force state EMPTY with count=0, cur_min=cur_max=win_min=win_max=16'h0000, win_sign=0, and new_min=new_max=done=0.
REQ-032 rst SHALL override clear and in_valid, and reset mid-window SHALL discard the partial window.
REQ-033 in_ready SHALL be low while rst=1.

Verification
REQ-034 Signed window (WIN=8, sign=1): samples 1,2,1,256,257,256,2,-1 -> done pulses one cycle after the 8th sample with win_min=-1 (16'hFFFF) and win_max=257.
REQ-035 Unsigned window (sign=0), same samples -> win_min=1 and win_max=16'hFFFF; new_max pulses on the 8th sample.
REQ-036 Signed window with samples -256,257,-257,... -> new_min pulses on -257; ties (-256 repeated) produce no pulse.
REQ-037 clear after 5 samples, then 8 fresh samples -> count returns to 0, a single done pulse after the 8th fresh sample, and the prior win_* values are held until then.
REQ-038 Back-to-back in_valid=1 -> in_ready is low exactly one cycle per window (DONE), and no sample is lost or duplicated.
REQ-039 rst asserted mid-window, and sign toggled mid-window -> outputs take REQ-031 values; the toggled sign is ignored until the next window.
